// File: rtl/regfile_scoreboard.sv
// Integer register file (2 async reads, 1 sync write, r0 = 0, optional write bypass)
// with a per-register pending-write scoreboard that tells decode when to stall.
module regfile_scoreboard #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int BYPASS = 1,
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              busy1,
  output logic              busy2,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  output logic              iss_ready,
  input  logic              flush
);

  localparam int              DEPTH   = 2 ** ADDR_W;
  localparam bit              BYP     = (BYPASS != 0);
  localparam logic [PEND_W-1:0] PMAX    = '1;
  localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

  logic [DATA_W-1:0] rf_q  [DEPTH];
  logic [PEND_W-1:0] cnt_q [DEPTH];
  logic [PEND_W-1:0] cnt_d [DEPTH];

  logic wr_en;
  logic retire;
  logic issue;

  assign wr_en  = we && (waddr != '0);
  // A write to a register nobody is waiting on leaves the scoreboard untouched.
  assign retire = wr_en && (cnt_q[waddr] != '0);

  // A saturated destination can still be issued to if its oldest write retires now.
  assign iss_ready = (iss_rd == '0) || (cnt_q[iss_rd] != PMAX) ||
                     (retire && (waddr == iss_rd));
  assign issue     = iss_valid && iss_ready && (iss_rd != '0);

  assign rd1 = (ra1 == '0)                     ? '0    :
               (BYP && we && (waddr == ra1))   ? wdata :
                                                 rf_q[ra1];
  assign rd2 = (ra2 == '0)                     ? '0    :
               (BYP && we && (waddr == ra2))   ? wdata :
                                                 rf_q[ra2];

  // The last outstanding write being forwarded this cycle means the source is usable.
  assign busy1 = (ra1 != '0) && (cnt_q[ra1] != '0) &&
                 !(BYP && retire && (waddr == ra1) && (cnt_q[ra1] == CNT_ONE));
  assign busy2 = (ra2 != '0) && (cnt_q[ra2] != '0) &&
                 !(BYP && retire && (waddr == ra2) && (cnt_q[ra2] == CNT_ONE));

  // NOTE: combinational next-state uses blocking '=' with every output given a
  // default first, so no latch can be inferred.
  always_comb begin
    cnt_d[0] = '0;
    for (int i = 1; i < DEPTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (flush) begin
        cnt_d[i] = '0;
      end else if (issue && (iss_rd == ADDR_W'(i)) &&
                   !(retire && (waddr == ADDR_W'(i))) && (cnt_q[i] != PMAX)) begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end else if (retire && (waddr == ADDR_W'(i)) &&
                   !(issue && (iss_rd == ADDR_W'(i)))) begin
        cnt_d[i] = cnt_q[i] - CNT_ONE;
      end
    end
  end

  // NOTE: the register array is cleared by reset on purpose, since reads after
  // reset must return zero; this keeps it out of plain RAM macros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) rf_q[i] <= '0;
    end else if (wr_en) begin
      rf_q[waddr] <= wdata;
    end
  end

  // NOTE: sequential state is updated only with non-blocking '<='.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: a bypassing and a non-bypassing instance
// share the same stimulus; expected values are hand-computed constants.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  ra1, ra2;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        flush;

  logic [31:0] rd1, rd2, rd1_nb, rd2_nb;
  logic        busy1, busy2, busy1_nb, busy2_nb;
  logic        iss_ready, iss_ready_nb;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(.ADDR_W(5), .DATA_W(32), .BYPASS(1), .PEND_W(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .busy1(busy1), .busy2(busy2),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready), .flush(flush)
  );

  regfile_scoreboard #(.ADDR_W(5), .DATA_W(32), .BYPASS(0), .PEND_W(2)) u_dut_nb (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_nb), .rd2(rd2_nb), .busy1(busy1_nb), .busy2(busy2_nb),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready_nb), .flush(flush)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow a further #1.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; ra1 = '0; ra2 = '0;
    iss_valid = 1'b0; iss_rd = 5'd3; flush = 1'b0;
    #1;
    check("reset_rd1",       32'(rd1),       32'h0);
    check("reset_busy1",     32'(busy1),     32'h0);
    check("reset_iss_ready", 32'(iss_ready), 32'h1);
    #11 rst_n = 1'b1;

    // Plain write then read; writes to r0 are dropped.
    tick();
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    tick();
    we = 1'b0; ra1 = 5'd5;
    #1;
    check("rd1_r5",    rd1,    32'hDEADBEEF);
    check("rd1_r5_nb", rd1_nb, 32'hDEADBEEF);
    we = 1'b1; waddr = 5'd0; wdata = 32'h1234; ra2 = 5'd0;
    #1;
    check("rd2_r0_same_cycle", rd2, 32'h0);
    tick();
    we = 1'b0;
    #1;
    check("rd2_r0_after",    rd2,    32'h0);
    check("rd2_r0_after_nb", rd2_nb, 32'h0);

    // Bypass: same-cycle write forwarded only by the BYPASS=1 build.
    we = 1'b1; waddr = 5'd7; wdata = 32'h11;
    tick();
    wdata = 32'h55; ra1 = 5'd7;
    #1;
    check("bypass_rd1",    rd1,    32'h55);
    check("nobypass_rd1",  rd1_nb, 32'h11);
    tick();
    we = 1'b0;
    #1;
    check("nobypass_rd1_next", rd1_nb, 32'h55);

    // Saturate r3 at 3 pending writes.
    iss_valid = 1'b1; iss_rd = 5'd3; ra1 = 5'd3;
    #1;
    check("iss3_ready_cnt0", 32'(iss_ready), 32'h1);
    tick(); tick(); tick();
    #1;
    check("iss3_ready_sat", 32'(iss_ready), 32'h0);
    check("busy1_r3_sat",   32'(busy1),     32'h1);
    we = 1'b1; waddr = 5'd3; wdata = 32'h33;
    #1;
    check("iss3_ready_retire", 32'(iss_ready), 32'h1);
    check("busy1_r3_retire3",  32'(busy1),     32'h1);
    tick();
    we = 1'b0;
    #1;
    check("iss3_ready_still_sat", 32'(iss_ready), 32'h0);
    iss_rd = 5'd0;
    #1;
    check("iss_r0_ready", 32'(iss_ready), 32'h1);
    iss_valid = 1'b0; iss_rd = 5'd3;
    we = 1'b1; waddr = 5'd3;
    tick(); tick();
    #1;
    check("busy1_r3_last_fwd",    32'(busy1),    32'h0);
    check("busy1_r3_last_nofwd",  32'(busy1_nb), 32'h1);
    tick();
    we = 1'b0;
    #1;
    check("busy1_r3_drained", 32'(busy1),     32'h0);
    check("iss3_ready_drained", 32'(iss_ready), 32'h1);

    // Single pending write on r4 resolved by forwarding.
    iss_valid = 1'b1; iss_rd = 5'd4;
    tick();
    iss_valid = 1'b0; ra1 = 5'd4;
    #1;
    check("busy1_r4_pending", 32'(busy1), 32'h1);
    we = 1'b1; waddr = 5'd4; wdata = 32'h9;
    #1;
    check("busy1_r4_retire", 32'(busy1), 32'h0);
    check("rd1_r4_retire",   rd1,        32'h9);
    tick();
    we = 1'b0;
    #1;
    check("busy1_r4_after", 32'(busy1), 32'h0);
    check("rd1_r4_after",   rd1,        32'h9);

    // Flush overrides a same-cycle issue, but the data write still lands.
    iss_valid = 1'b1; iss_rd = 5'd2;
    tick(); tick();
    iss_valid = 1'b0; ra2 = 5'd2;
    #1;
    check("busy2_r2_pending", 32'(busy2), 32'h1);
    flush = 1'b1; we = 1'b1; waddr = 5'd2; wdata = 32'hAB; iss_valid = 1'b1;
    tick();
    flush = 1'b0; we = 1'b0; iss_valid = 1'b0;
    #1;
    check("busy2_after_flush", 32'(busy2), 32'h0);
    check("rd2_after_flush",   rd2,        32'hAB);
    we = 1'b1; wdata = 32'hCD;
    tick();
    we = 1'b0;
    #1;
    check("busy2_no_underflow", 32'(busy2), 32'h0);
    check("rd2_late_write",     rd2,        32'hCD);
    iss_valid = 1'b1;
    tick();
    iss_valid = 1'b0;
    #1;
    check("busy2_reissue", 32'(busy2), 32'h1);

    // Asynchronous reset mid-run with live counters.
    iss_valid = 1'b1; iss_rd = 5'd3; ra1 = 5'd3;
    tick(); tick(); tick();
    iss_valid = 1'b0;
    #1;
    check("pre_reset_ready", 32'(iss_ready), 32'h0);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_ready", 32'(iss_ready), 32'h1);
    check("async_reset_busy1", 32'(busy1),     32'h0);
    check("async_reset_busy2", 32'(busy2),     32'h0);
    check("async_reset_rd2",   rd2,            32'h0);
    ra1 = 5'd5;
    #1;
    check("async_reset_rd1_r5", rd1, 32'h0);
    tick();
    #1 rst_n = 1'b1;
    #1;
    check("post_reset_rd1_r5", rd1,            32'h0);
    check("post_reset_ready",  32'(iss_ready), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
